amstrad_audio_mixer: RTL and testbench
======================================

Name: amstrad_audio_mixer

Overview:
- Parametrised N-channel stereo audio mixer for the motherboard audio path.
- Replaces the fixed 3-channel PSG mix (A→L, C→R, B→both at half weight) with per-channel pan/gain codes and a time-multiplexed accumulator.
- Adds saturation, a mono fold-down mode and overrun detection.
- Sits between PSG(s) and any expansion sound sources (e.g. a second and third PSG) and the core's audio output.

Parameters:
NCH, 3, number of input channels (1..16)
IN_W, 8, unsigned sample width per channel
OUT_W, 9, unsigned output width; OUT_W >= IN_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ce  input  1  sample strobe, one clk wide; starts a mix pass
ch_in  input  NCH*IN_W  channel samples; channel k at bits [k*IN_W +: IN_W]
pan_l  input  NCH*2  left gain code per channel, channel k at [2k +: 2]
pan_r  input  NCH*2  right gain code per channel
mono  input  1  1 = both outputs carry (L+R)/2
audio_l  output  OUT_W  mixed left sample
audio_r  output  OUT_W  mixed right sample
valid  output  1  one-clk pulse when audio_l/audio_r update
busy  output  1  mix pass in progress
overrun  output  1  sticky; ce arrived while busy

Behaviour:
- Reset (async, active-high): audio_l = audio_r = 0, valid = 0, busy = 0, overrun = 0, accumulators = 0, idx = 0, state = IDLE. Reset asserted mid-pass aborts the pass; no partial output is ever presented.
- Gain codes: 0 → 0; 1 → v>>2; 2 → v>>1; 3 → v. Shifts truncate toward zero.
- Accumulator width: ACC_W = IN_W + clog2(NCH) + 1. No internal overflow is possible.
- State IDLE, ce=1:
  - snapshot ch_in, pan_l, pan_r and mono into registers;
  - clear acc_l and acc_r; idx = 0; busy = 1; → ACC.
- State ACC, each clk:
  - acc_l += gain(pan_l[idx], snap[idx]); acc_r += gain(pan_r[idx], snap[idx]);
  - idx == NCH-1 → SAT, else idx++.
- State SAT, one clk:
  - if snapshot mono = 1, both sides take m = (acc_l + acc_r) >> 1, computed at ACC_W+1 bits;
  - each side saturates to 2^OUT_W - 1;
  - audio_l and audio_r register the results; valid = 1 for this one clk; busy = 0; → IDLE.
- Latency: outputs and valid update on the (NCH+1)th rising edge after the edge that sampled ce. Minimum ce spacing is NCH+2 clks.
- ce while busy, including the SAT clk: ignored, the pass in progress is unaffected, overrun = 1. overrun is cleared only by reset.
- Input changes after the ce edge do not affect the pass in progress.
- audio_l and audio_r hold their value between passes.
- NCH = 1: ACC lasts one clk; latency 2.

Optional Feature:
Macro AUDIO_MIXER_PEAK_EN.
- Defined:
  - adds ports peak_clr (input, 1) and peak_l / peak_r (outputs, OUT_W, reset 0);
  - on each valid, peak_x = max(peak_x, audio_x new value);
  - peak_clr = 1 sets both peaks to 0; when peak_clr coincides with valid, the peaks load the new sample values.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, ch A=0xFF, B=0x80, C=0x40; pan_l={A:3, B:2, C:0}; pan_r={A:0, B:2, C:3}; single ce → on the 4th edge after ce: audio_l=319, audio_r=128, valid high for exactly 1 clk, busy low on the same edge.
- All channels 0xFF, all pans 3 → audio_l = audio_r = 511 (saturated from 765); then all pans 1 → 189 (63×3).
- mono=1 with the first scenario's inputs → audio_l = audio_r = 223 ((319+128)>>1); mono toggled after the ce edge → result unchanged.
- ce pulsed again 2 clks after the first ce → first result correct, no second pass, overrun=1 and stays 1 until reset.
- reset asserted 2 clks into a pass → all outputs 0 immediately (async); next ce after release gives a correct full result. With AUDIO_MIXER_PEAK_EN: samples 300 then 100 → peak_l=300; peak_clr → 0.

Source files
------------

// File: rtl/amstrad_audio_mixer.sv
// N-channel stereo mixer: per-channel pan/gain codes, time-multiplexed accumulation,
// output saturation, mono fold-down, sticky overrun. Optional peak meters: AUDIO_MIXER_PEAK_EN.
module amstrad_audio_mixer #(
  parameter int NCH   = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [NCH*IN_W-1:0]   ch_in,
  input  logic [NCH*2-1:0]      pan_l,
  input  logic [NCH*2-1:0]      pan_r,
  input  logic                  mono,
`ifdef AUDIO_MIXER_PEAK_EN
  input  logic                  peak_clr,
  output logic [OUT_W-1:0]      peak_l,
  output logic [OUT_W-1:0]      peak_r,
`endif
  output logic [OUT_W-1:0]      audio_l,
  output logic [OUT_W-1:0]      audio_r,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun
);
  localparam int ACC_W = IN_W + $clog2(NCH) + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WIDE  = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
  localparam logic [WIDE-1:0]  MAX_W = WIDE'((2 ** OUT_W) - 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0][IN_W-1:0] snap_ch;
  logic [NCH-1:0][1:0]      snap_pl, snap_pr;
  logic                     snap_mono;
  logic [IDX_W-1:0]         idx;
  logic [ACC_W-1:0]         acc_l, acc_r;
  logic [ACC_W:0]           sum_lr, sel_l, sel_r;
  logic [OUT_W-1:0]         out_l, out_r;
  logic [IN_W-1:0]          g_l, g_r;

  function automatic logic [IN_W-1:0] gain(input logic [1:0] code, input logic [IN_W-1:0] v);
    case (code)
      2'd0:    gain = '0;
      2'd1:    gain = v >> 2;
      2'd2:    gain = v >> 1;
      default: gain = v;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W:0] v);
    logic [WIDE-1:0] w;
    w   = WIDE'(v);
    sat = (w > MAX_W) ? {OUT_W{1'b1}} : w[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce) state_nxt = ACC;
      ACC:     if (idx == LAST) state_nxt = SAT;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign g_l  = gain(snap_pl[idx], snap_ch[idx]);
  assign g_r  = gain(snap_pr[idx], snap_ch[idx]);

  // Mono average is taken one bit wider so the sum cannot wrap before halving.
  always_comb begin
    sum_lr = {1'b0, acc_l} + {1'b0, acc_r};
    sel_l  = snap_mono ? (sum_lr >> 1) : {1'b0, acc_l};
    sel_r  = snap_mono ? (sum_lr >> 1) : {1'b0, acc_r};
    out_l  = sat(sel_l);
    out_r  = sat(sel_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_ch   <= '0;
      snap_pl   <= '0;
      snap_pr   <= '0;
      snap_mono <= 1'b0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid <= (state == SAT);
      if (ce && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (ce) begin
          snap_ch   <= ch_in;
          snap_pl   <= pan_l;
          snap_pr   <= pan_r;
          snap_mono <= mono;
          idx       <= '0;
          acc_l     <= '0;
          acc_r     <= '0;
        end
        ACC: begin
          acc_l <= acc_l + {{(ACC_W-IN_W){1'b0}}, g_l};
          acc_r <= acc_r + {{(ACC_W-IN_W){1'b0}}, g_r};
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: begin
          audio_l <= out_l;
          audio_r <= out_r;
        end
      endcase
    end
  end

`ifdef AUDIO_MIXER_PEAK_EN
  // A clear coinciding with a new sample restarts the peaks from that sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (peak_clr) begin
      peak_l <= (state == SAT) ? out_l : '0;
      peak_r <= (state == SAT) ? out_r : '0;
    end else if (state == SAT) begin
      if (out_l > peak_l) peak_l <= out_l;
      if (out_r > peak_r) peak_r <= out_r;
    end
  end
`endif
endmodule

// File: tb/tb_amstrad_audio_mixer.sv
// Randomized and directed bench for amstrad_audio_mixer against an arithmetic reference model.
module tb_amstrad_audio_mixer;
  localparam int NCH = 3, IN_W = 8, OUT_W = 9;
  localparam int MAXO = (1 << OUT_W) - 1;

  logic clk = 0, reset = 1, ce = 0, mono = 0;
  logic [NCH*IN_W-1:0] ch_in = '0;
  logic [NCH*2-1:0] pan_l = '0, pan_r = '0;
  logic [OUT_W-1:0] audio_l, audio_r;
  logic valid, busy, overrun;
`ifdef AUDIO_MIXER_PEAK_EN
  logic peak_clr = 0;
  logic [OUT_W-1:0] peak_l, peak_r;
`endif

  amstrad_audio_mixer #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .ch_in(ch_in), .pan_l(pan_l), .pan_r(pan_r),
    .mono(mono),
`ifdef AUDIO_MIXER_PEAK_EN
    .peak_clr(peak_clr), .peak_l(peak_l), .peak_r(peak_r),
`endif
    .audio_l(audio_l), .audio_r(audio_r), .valid(valid), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cur_ch[NCH], cur_pl[NCH], cur_pr[NCH];
  int exp_l, exp_r;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain_m(input int code, input int v);
    case (code)
      0: return 0;
      1: return v / 4;
      2: return v / 2;
      default: return v;
    endcase
  endfunction

  task automatic model(input bit m);
    int l, r;
    l = 0; r = 0;
    for (int k = 0; k < NCH; k++) begin
      l += gain_m(cur_pl[k], cur_ch[k]);
      r += gain_m(cur_pr[k], cur_ch[k]);
    end
    if (m) begin l = (l + r) / 2; r = l; end
    exp_l = (l > MAXO) ? MAXO : l;
    exp_r = (r > MAXO) ? MAXO : r;
  endtask

  task automatic drive_cur(input bit m);
    for (int k = 0; k < NCH; k++) begin
      ch_in[k*IN_W +: IN_W] = IN_W'(cur_ch[k]);
      pan_l[2*k +: 2] = 2'(cur_pl[k]);
      pan_r[2*k +: 2] = 2'(cur_pr[k]);
    end
    mono = m;
  endtask

  // One pass: ce for one clk, scramble inputs afterwards, optionally re-pulse ce while busy.
  task automatic run_pass(input string tag, input bit m, input bit dup);
    int got, extra;
    model(m);
    @(negedge clk);
    drive_cur(m);
    ce = 1;
    @(posedge clk); #1;
    chk({tag, " busy"}, busy, 1);
    @(negedge clk);
    ce = 0;
    ch_in = $urandom; pan_l = 6'($urandom); pan_r = 6'($urandom); mono = ~m;
    got = -1;
    for (int n = 1; n <= NCH + 6; n++) begin
      @(posedge clk); #1;
      if (valid) begin got = n; break; end
      @(negedge clk);
      ce = dup && (n == 1);
    end
    ce = 0;
    chk({tag, " latency"}, got, NCH + 1);
    chk({tag, " audio_l"}, audio_l, exp_l);
    chk({tag, " audio_r"}, audio_r, exp_r);
    chk({tag, " busy_end"}, busy, 0);
    extra = 0;
    for (int n = 0; n < NCH + 3; n++) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    chk({tag, " extra_valid"}, extra, 0);
    chk({tag, " hold_l"}, audio_l, exp_l);
  endtask

  task automatic set_scn1();
    cur_ch = '{255, 128, 64};
    cur_pl = '{3, 2, 0};
    cur_pr = '{0, 2, 3};
  endtask

  initial begin
    #12;
    chk("rst audio_l", audio_l, 0);
    chk("rst audio_r", audio_r, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    @(negedge clk); reset = 0;

`ifdef AUDIO_MIXER_PEAK_EN
    cur_ch = '{255, 90, 0}; cur_pl = '{3, 2, 0}; cur_pr = '{0, 0, 0};
    run_pass("pk300", 0, 0);
    cur_ch = '{100, 0, 0}; cur_pl = '{3, 0, 0};
    run_pass("pk100", 0, 0);
    chk("peak_l max", peak_l, 300);
    chk("peak_r max", peak_r, 0);
    @(negedge clk); peak_clr = 1;
    @(negedge clk); peak_clr = 0;
    chk("peak_l clr", peak_l, 0);
`endif

    set_scn1();
    run_pass("scn1", 0, 0);
    chk("scn1 model_l", exp_l, 319);
    chk("scn1 model_r", exp_r, 128);

    cur_ch = '{255, 255, 255}; cur_pl = '{3, 3, 3}; cur_pr = '{3, 3, 3};
    run_pass("sat", 0, 0);
    cur_pl = '{1, 1, 1}; cur_pr = '{1, 1, 1};
    run_pass("quarter", 0, 0);

    set_scn1();
    run_pass("mono", 1, 0);
    chk("mono value", audio_l, 223);

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NCH; k++) begin
        cur_ch[k] = $urandom_range(0, 255);
        cur_pl[k] = $urandom_range(0, 3);
        cur_pr[k] = $urandom_range(0, 3);
      end
      run_pass($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 0);
    end
    chk("overrun pre", overrun, 0);

    set_scn1();
    run_pass("dup", 0, 1);
    chk("overrun set", overrun, 1);
    run_pass("after_dup", 0, 0);
    chk("overrun sticky", overrun, 1);

    // Reset two clocks into a pass.
    @(negedge clk);
    cur_ch = '{200, 10, 30}; drive_cur(0); ce = 1;
    @(negedge clk); ce = 0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1; #1;
    chk("arst audio_l", audio_l, 0);
    chk("arst audio_r", audio_r, 0);
    chk("arst busy", busy, 0);
    chk("arst valid", valid, 0);
    chk("arst overrun", overrun, 0);
    @(negedge clk); reset = 0;
    begin
      int cnt;
      cnt = 0;
      for (int n = 0; n < NCH + 3; n++) begin
        @(posedge clk); #1;
        if (valid) cnt++;
      end
      chk("arst no_partial", cnt, 0);
    end
    set_scn1();
    run_pass("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
